// File: rtl/s420_pkg.sv
// Shared constants and types for the s420 Z-line receiver.
package s420_pkg;

  localparam int unsigned NBITS = 17;
  localparam int unsigned CW    = 5;

  typedef logic [CW-1:0] slot_t;

  // Slot index carrying C_16; the counter wraps to 0 after it.
  localparam slot_t LAST_SLOT = slot_t'(NBITS - 1);

endpackage

// File: rtl/s420_slot_ctr.sv
// Slot counter for the s420 receiver.
// Ports:
//   clk         clock
//   rst         synchronous active-high reset
//   sync        frame restart, forces slot to 0 and suppresses the frame end
//   en          slot enable (P_0)
//   slot        current slot index, registered
//   frame_end_c combinational strobe: the current cycle samples the last slot
module s420_slot_ctr
  import s420_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  sync,
  input  logic  en,
  output slot_t slot,
  output logic  frame_end_c
);

  logic clr_c;

  assign clr_c       = rst | sync;
  assign frame_end_c = en & ~clr_c & (slot == LAST_SLOT);

  // Explicit wrap at LAST_SLOT keeps the index inside 0..NBITS-1.
  always_ff @(posedge clk) begin
    if (clr_c) begin
      slot <= '0;
    end else if (en) begin
      if (slot == LAST_SLOT) begin
        slot <= '0;
      end else begin
        slot <= slot + slot_t'(1);
      end
    end
  end

endmodule

// File: rtl/s420_deser.sv
// Serial-to-parallel receiver for the s420 scan stream: assembles C_0..C_16
// from Z and hands complete frames downstream with a valid/ack handshake.
// Ports:
//   CK     clock
//   RST    synchronous active-high reset
//   P_0    slot enable; Z is sampled and the slot advances only when high
//   SYNC   frame restart; discards the partial frame
//   Z      serial data for the current slot
//   ACK    consumer accepts C_OUT while VALID is high
//   C_OUT  last complete frame, C_OUT[k] = slot k
//   VALID  frame available in C_OUT
//   OVR    sticky overrun flag, cleared only by RST
//   SLOT   current slot index
module s420_deser
  import s420_pkg::*;
(
  input  logic             CK,
  input  logic             RST,
  input  logic             P_0,
  input  logic             SYNC,
  input  logic             Z,
  input  logic             ACK,
  output logic [NBITS-1:0] C_OUT,
  output logic             VALID,
  output logic             OVR,
  output slot_t            SLOT
);

  logic [NBITS-1:0] asm_q;
  logic [NBITS-1:0] asm_next_c;
  logic [NBITS-1:0] frame_c;
  logic             frame_end_c;

  s420_slot_ctr u_slot_ctr (
    .clk         (CK),
    .rst         (RST),
    .sync        (SYNC),
    .en          (P_0),
    .slot        (SLOT),
    .frame_end_c (frame_end_c)
  );

  // Write Z into the bit addressed by the current slot.
  always_comb begin
    asm_next_c = asm_q;
    for (int k = 0; k < NBITS; k++) begin
      if (SLOT == slot_t'(k)) begin
        asm_next_c[k] = Z;
      end
    end
  end

  // The final bit bypasses asm so the frame is complete on the sampling edge.
  assign frame_c = {Z, asm_q[NBITS-2:0]};

  // Assembly register, output frame and handshake.
  always_ff @(posedge CK) begin
    if (RST) begin
      asm_q <= '0;
      C_OUT <= '0;
      VALID <= 1'b0;
      OVR   <= 1'b0;
    end else begin
      if (SYNC) begin
        asm_q <= '0;
      end else if (P_0) begin
        asm_q <= asm_next_c;
      end

      if (frame_end_c) begin
        C_OUT <= frame_c;
        VALID <= 1'b1;
        if (VALID && !ACK) begin
          OVR <= 1'b1;
        end
      end else if (ACK) begin
        VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_s420_deser.sv
// Directed bench for s420_deser: a vector table plus hand-written sequences.
module tb_s420_deser;
  import s420_pkg::*;

  logic             CK   = 1'b0;
  logic             RST  = 1'b0;
  logic             P_0  = 1'b0;
  logic             SYNC = 1'b0;
  logic             Z    = 1'b0;
  logic             ACK  = 1'b0;
  logic [NBITS-1:0] C_OUT;
  logic             VALID;
  logic             OVR;
  slot_t            SLOT;

  localparam logic [16:0] F1 = 17'h1A5C3;
  localparam logic [16:0] FA = 17'h0FFFF;
  localparam logic [16:0] FB = 17'h10000;
  localparam logic [16:0] FS = 17'h00001;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string       tag;
    logic        rst, p0, sync, z, ack;
    slot_t       slot;
    logic        valid, ovr;
    logic [16:0] cout;
  } vec_t;

  vec_t vq[$];

  s420_deser dut (
    .CK    (CK),
    .RST   (RST),
    .P_0   (P_0),
    .SYNC  (SYNC),
    .Z     (Z),
    .ACK   (ACK),
    .C_OUT (C_OUT),
    .VALID (VALID),
    .OVR   (OVR),
    .SLOT  (SLOT)
  );

  always #5 CK = ~CK;

  task automatic add(input string tag, input logic rst, input logic p0, input logic sync,
                     input logic z, input logic ack, input slot_t s, input logic v,
                     input logic o, input logic [16:0] c);
    vec_t e;
    e.tag = tag; e.rst = rst; e.p0 = p0; e.sync = sync; e.z = z; e.ack = ack;
    e.slot = s; e.valid = v; e.ovr = o; e.cout = c;
    vq.push_back(e);
  endtask

  // Seventeen enabled slots, LSB first; ACK only on the frame-end cycle if ack_end.
  task automatic add_frame(input string tag, input logic [16:0] f, input logic ack_end,
                           input logic [16:0] prev_c, input logic prev_v,
                           input logic ovr_before, input logic ovr_end);
    for (int i = 0; i < 17; i++) begin
      if (i == 16)
        add(tag, 1'b0, 1'b1, 1'b0, f[i], ack_end, slot_t'(0), 1'b1, ovr_end, f);
      else
        add(tag, 1'b0, 1'b1, 1'b0, f[i], 1'b0, slot_t'(i + 1), prev_v, ovr_before, prev_c);
    end
  endtask

  task automatic step(input logic rst, input logic p0, input logic sync, input logic z,
                      input logic ack);
    RST = rst; P_0 = p0; SYNC = sync; Z = z; ACK = ack;
    @(posedge CK);
    #1;
  endtask

  task automatic check(input string tag, input slot_t s, input logic v, input logic o,
                       input logic [16:0] c);
    n_vec++;
    if ({SLOT, VALID, OVR, C_OUT} !== {s, v, o, c}) begin
      n_err++;
      $display("FAIL %s: got slot=%0d valid=%b ovr=%b c_out=%h, want slot=%0d valid=%b ovr=%b c_out=%h",
               tag, SLOT, VALID, OVR, C_OUT, s, v, o, c);
    end
  endtask

  initial begin
    logic [16:0] f;

    // Reset, basic frame, ack behaviour, overrun and ack-on-frame-end.
    add("reset", 1, 0, 0, 0, 0, 0, 0, 0, 17'h0);
    add("reset", 1, 0, 0, 0, 0, 0, 0, 0, 17'h0);
    add_frame("frame_1a5c3", F1, 1'b0, 17'h0, 1'b0, 1'b0, 1'b0);
    add("ack_clears_valid", 0, 0, 0, 0, 1, 0, 0, 0, F1);
    add("ack_while_idle", 0, 0, 0, 0, 1, 0, 0, 0, F1);
    add("p0_low_holds", 0, 0, 0, 1, 0, 0, 0, 0, F1);
    add_frame("frame_0ffff", FA, 1'b0, F1, 1'b0, 1'b0, 1'b0);
    add_frame("overrun_10000", FB, 1'b0, FA, 1'b1, 1'b0, 1'b1);
    add("ovr_sticky", 0, 0, 0, 0, 1, 0, 0, 1, FB);
    add("reset_clears_ovr", 1, 0, 0, 0, 0, 0, 0, 0, 17'h0);
    add_frame("frame_0ffff_b", FA, 1'b0, 17'h0, 1'b0, 1'b0, 1'b0);
    add_frame("ack_on_end", FB, 1'b1, FA, 1'b1, 1'b0, 1'b0);
    add("ack_after", 0, 0, 0, 0, 1, 0, 0, 0, FB);

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].rst, vq[i].p0, vq[i].sync, vq[i].z, vq[i].ack);
      check(vq[i].tag, vq[i].slot, vq[i].valid, vq[i].ovr, vq[i].cout);
    end

    // P_0 toggling: disabled cycles carry inverted garbage on Z.
    step(1, 0, 0, 0, 0);
    f = F1;
    for (int i = 0; i < 17; i++) begin
      step(0, 1, 0, f[i], 0);
      check("gap_enabled", (i == 16) ? slot_t'(0) : slot_t'(i + 1), i == 16, 1'b0,
            (i == 16) ? F1 : 17'h0);
      step(0, 0, 0, ~f[i], 0);
      check("gap_disabled", (i == 16) ? slot_t'(0) : slot_t'(i + 1), i == 16, 1'b0,
            (i == 16) ? F1 : 17'h0);
    end

    // SYNC after 8 slots discards the partial frame and blocks capture that cycle.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 0, 1, 0);
    check("eight_slots", slot_t'(8), 1'b0, 1'b0, 17'h0);
    step(0, 1, 1, 1, 0);
    check("sync_restart", slot_t'(0), 1'b0, 1'b0, 17'h0);
    f = FS;
    for (int i = 0; i < 17; i++) step(0, 1, 0, f[i], 0);
    check("frame_after_sync", slot_t'(0), 1'b1, 1'b0, FS);

    // SYNC with a frame pending leaves VALID/C_OUT alone; RST mid-frame clears all.
    step(1, 0, 0, 0, 0);
    f = F1;
    for (int i = 0; i < 17; i++) step(0, 1, 0, f[i], 0);
    check("pending_frame", slot_t'(0), 1'b1, 1'b0, F1);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 0);
    step(0, 1, 1, 0, 0);
    check("sync_keeps_valid", slot_t'(0), 1'b1, 1'b0, F1);
    for (int i = 0; i < 10; i++) step(0, 1, 0, 1, 0);
    check("slot_ten", slot_t'(10), 1'b1, 1'b0, F1);
    step(1, 1, 0, 1, 0);
    check("reset_mid_frame", slot_t'(0), 1'b0, 1'b0, 17'h0);
    step(0, 1, 0, 1, 0);
    check("restart_slot0", slot_t'(1), 1'b0, 1'b0, 17'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
